// File: rtl/csr_unit.sv
// RV64 machine-mode CSR file: csrrw/csrrs/csrrc, trap entry/mret sequencing, mcycle/minstret counters.
// Reads are combinational (old value); all updates land at the next posedge; no backpressure, one op per cycle.
module csr_unit #(
    parameter int unsigned      XLEN         = 64,
    parameter logic [XLEN-1:0]  HART_ID      = '0,
    parameter logic [XLEN-1:0]  MTVEC_RESET  = '0,
    parameter bit               HAS_COUNTERS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            retire,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mie_out
);

    localparam logic [1:0]      OP_RW      = 2'b01;
    localparam logic [1:0]      OP_RS      = 2'b10;
    localparam logic [11:0]     A_MSTATUS  = 12'h300;
    localparam logic [11:0]     A_MTVEC    = 12'h305;
    localparam logic [11:0]     A_MSCRATCH = 12'h340;
    localparam logic [11:0]     A_MEPC     = 12'h341;
    localparam logic [11:0]     A_MCAUSE   = 12'h342;
    localparam logic [11:0]     A_MCYCLE   = 12'hB00;
    localparam logic [11:0]     A_MINSTRET = 12'hB02;
    localparam logic [11:0]     A_MHARTID  = 12'hF14;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d, mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic            addr_impl, op_active, wr_attempt, csr_we;
    logic [XLEN-1:0] mstatus_rd, old_val, new_val;

    // MPP is hardwired to M-mode; only MIE and MPIE are live.
    assign mstatus_rd = XLEN'({2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

    always_comb begin
        addr_impl = 1'b1;
        old_val   = '0;
        case (csr_addr)
            A_MSTATUS:  old_val = mstatus_rd;
            A_MTVEC:    old_val = mtvec_q;
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MHARTID:  old_val = HART_ID;
            A_MCYCLE:   begin addr_impl = HAS_COUNTERS; old_val = mcycle_q;   end
            A_MINSTRET: begin addr_impl = HAS_COUNTERS; old_val = minstret_q; end
            default:    addr_impl = 1'b0;
        endcase
    end

    assign op_active   = csr_valid & (csr_op != 2'b00);
    assign wr_attempt  = (csr_op == OP_RW) | (csr_wdata != '0);
    assign csr_illegal = op_active & (~addr_impl | ((csr_addr[11:10] == 2'b11) & wr_attempt));
    assign csr_we      = op_active & wr_attempt & ~csr_illegal & ~trap_valid & ~mret_valid;

    always_comb begin
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            default: new_val = old_val & ~csr_wdata;
        endcase
    end

    assign csr_rdata      = old_val;
    assign redirect_valid = trap_valid | mret_valid;
    assign redirect_pc    = trap_valid ? mtvec_q : (mret_valid ? mepc_q : '0);
    assign mie_out        = mie_q;

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mcycle_d   = HAS_COUNTERS ? mcycle_q + XLEN'(1) : '0;
        minstret_d = (HAS_COUNTERS && retire) ? minstret_q + XLEN'(1) : minstret_q;
        // Trap beats mret beats CSR write; csr_we already excludes the first two.
        if (trap_valid) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                A_MSTATUS:  begin mie_d = new_val[3]; mpie_d = new_val[7]; end
                A_MTVEC:    mtvec_d    = new_val & ALIGN_MASK;
                A_MSCRATCH: mscratch_d = new_val;
                A_MEPC:     mepc_d     = new_val & ALIGN_MASK;
                A_MCAUSE:   mcause_d   = new_val;
                A_MCYCLE:   mcycle_d   = new_val;
                A_MINSTRET: minstret_d = new_val;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN_MASK;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Testbench for csr_unit: directed scenarios plus randomized traffic against a behavioural CSR model.
module tb_csr_unit;

    localparam int unsigned XLEN    = 64;
    localparam logic [63:0] HART_ID = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_valid = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h0;
    logic [63:0] csr_wdata = 64'h0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid = 1'b0;
    logic [63:0] trap_cause = 64'h0;
    logic [63:0] trap_pc = 64'h0;
    logic        mret_valid = 1'b0;
    logic        retire = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mie_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit          m_mie = 0, m_mpie = 0;
    logic [63:0] m_mtvec = 0, m_mepc = 0, m_mcause = 0, m_mscratch = 0, m_mcycle = 0, m_minstret = 0;

    csr_unit #(.XLEN(XLEN), .HART_ID(HART_ID), .MTVEC_RESET(64'h0), .HAS_COUNTERS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid), .retire(retire),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mie_out(mie_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_mie ? 64'h8 : 64'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle;
            12'hB02: return m_minstret;
            12'hF14: return HART_ID;
            default: return 64'h0;
        endcase
    endfunction

    function automatic bit m_known(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hF14};
    endfunction

    function automatic bit m_illegal(input bit v, input logic [1:0] op, input logic [11:0] a,
                                     input logic [63:0] wd);
        bit writes = (op == 2'd1) || (wd != 0);
        return v && op != 0 && (!m_known(a) || (a >= 12'hC00 && writes));
    endfunction

    function automatic logic [63:0] m_redirect();
        if (trap_valid) return m_mtvec;
        if (mret_valid) return m_mepc;
        return 64'h0;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        logic [63:0] old, nv, cyc, ins;
        bit wr;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
            m_mscratch = 0; m_mcycle = 0; m_minstret = 0;
            return;
        end
        old = m_read(csr_addr);
        wr  = csr_valid && csr_op != 0 && (csr_op == 1 || csr_wdata != 0) &&
              !m_illegal(csr_valid, csr_op, csr_addr, csr_wdata) && !trap_valid && !mret_valid;
        if (csr_op == 1)      nv = csr_wdata;
        else if (csr_op == 2) nv = old | csr_wdata;
        else                  nv = old & ~csr_wdata;
        cyc = m_mcycle + 1;
        ins = m_minstret + (retire ? 64'd1 : 64'd0);
        if (trap_valid) begin
            m_mepc = trap_pc & ~64'd3; m_mcause = trap_cause; m_mpie = m_mie; m_mie = 0;
        end else if (mret_valid) begin
            m_mie = m_mpie; m_mpie = 1;
        end else if (wr) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h305: m_mtvec = nv & ~64'd3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~64'd3;
                12'h342: m_mcause = nv;
                12'hB00: cyc = nv;
                12'hB02: ins = nv;
                default: ;
            endcase
        end
        m_mcycle = cyc; m_minstret = ins;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd,
                         input bit tv, input logic [63:0] tc, input logic [63:0] tp, input bit mv, input bit rt);
        csr_valid = v; csr_op = op; csr_addr = a; csr_wdata = wd;
        trap_valid = tv; trap_cause = tc; trap_pc = tp; mret_valid = mv; retire = rt;
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        drive(1, 2'b10, a, 64'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        rd(12'h300);
        n_cmp++; if (csr_rdata !== 64'h1800) begin n_bad++; $display("FAIL reset_mstatus got %h want %h", csr_rdata, 64'h1800); end
        n_cmp++; if (mie_out !== 1'b0) begin n_bad++; $display("FAIL reset_mie got %b want 0", mie_out); end
        n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 64'h0) begin n_bad++; $display("FAIL reset_redirect got %b/%h want 0/0", redirect_valid, redirect_pc); end
        n_cmp++; if (csr_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", csr_illegal); end
        tick();
        rd(12'h305);
        n_cmp++; if (csr_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_mtvec got %h want 0", csr_rdata); end
        tick();
        rd(12'hB00);
        n_cmp++; if (csr_rdata !== 64'd2) begin n_bad++; $display("FAIL reset_mcycle got %h want 2", csr_rdata); end
        tick();
    endtask

    task automatic test_mtvec();
        drive(1, 2'b01, 12'h305, 64'h8000_0103, 0, 0, 0, 0, 0);
        n_cmp++; if (csr_rdata !== 64'h0) begin n_bad++; $display("FAIL mtvec_old got %h want 0", csr_rdata); end
        tick();
        rd(12'h305);
        n_cmp++; if (csr_rdata !== 64'h8000_0100) begin n_bad++; $display("FAIL mtvec_new got %h want %h", csr_rdata, 64'h8000_0100); end
        tick();
    endtask

    task automatic test_trap_mret();
        drive(1, 2'b10, 12'h300, 64'h8, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (mie_out !== 1'b1) begin n_bad++; $display("FAIL set_mie got %b want 1", mie_out); end
        drive(0, 0, 0, 0, 1, 64'hB, 64'h8000_0046, 0, 0);
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100) begin n_bad++; $display("FAIL trap_redirect got %b/%h want 1/%h", redirect_valid, redirect_pc, 64'h8000_0100); end
        tick();
        rd(12'h341);
        n_cmp++; if (csr_rdata !== 64'h8000_0044) begin n_bad++; $display("FAIL trap_mepc got %h want %h", csr_rdata, 64'h8000_0044); end
        tick();
        rd(12'h342);
        n_cmp++; if (csr_rdata !== 64'hB) begin n_bad++; $display("FAIL trap_mcause got %h want b", csr_rdata); end
        tick();
        rd(12'h300);
        n_cmp++; if (csr_rdata !== 64'h1880) begin n_bad++; $display("FAIL trap_mstatus got %h want 1880", csr_rdata); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0044) begin n_bad++; $display("FAIL mret_redirect got %b/%h want 1/%h", redirect_valid, redirect_pc, 64'h8000_0044); end
        tick();
        rd(12'h300);
        n_cmp++; if (csr_rdata !== 64'h1888) begin n_bad++; $display("FAIL mret_mstatus got %h want 1888", csr_rdata); end
        n_cmp++; if (mie_out !== 1'b1) begin n_bad++; $display("FAIL mret_mie got %b want 1", mie_out); end
        tick();
    endtask

    task automatic test_illegal();
        drive(1, 2'b01, 12'hF14, 64'h123, 0, 0, 0, 0, 0);
        n_cmp++; if (csr_illegal !== 1'b1) begin n_bad++; $display("FAIL rw_mhartid_illegal got %b want 1", csr_illegal); end
        tick();
        rd(12'hF14);
        n_cmp++; if (csr_illegal !== 1'b0) begin n_bad++; $display("FAIL rs0_mhartid_illegal got %b want 0", csr_illegal); end
        n_cmp++; if (csr_rdata !== HART_ID) begin n_bad++; $display("FAIL mhartid_value got %h want %h", csr_rdata, HART_ID); end
        tick();
        drive(1, 2'b01, 12'h7C0, 64'h77, 0, 0, 0, 0, 0);
        n_cmp++; if (csr_illegal !== 1'b1 || csr_rdata !== 64'h0) begin n_bad++; $display("FAIL unimpl_access got %b/%h want 1/0", csr_illegal, csr_rdata); end
        tick();
        drive(1, 2'b00, 12'h7C0, 64'h77, 0, 0, 0, 0, 0);
        n_cmp++; if (csr_illegal !== 1'b0) begin n_bad++; $display("FAIL nop_illegal got %b want 0", csr_illegal); end
        tick();
    endtask

    task automatic test_counters();
        drive(1, 2'b01, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0);
        tick();
        rd(12'hB00);
        n_cmp++; if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mcycle_written got %h want fffffffffffffffe", csr_rdata); end
        tick();
        rd(12'hB00);
        n_cmp++; if (csr_rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mcycle_max got %h want ffffffffffffffff", csr_rdata); end
        tick();
        rd(12'hB00);
        n_cmp++; if (csr_rdata !== 64'h0) begin n_bad++; $display("FAIL mcycle_wrap got %h want 0", csr_rdata); end
        tick();
        drive(1, 2'b01, 12'hB02, 64'd5, 0, 0, 0, 0, 1);
        tick();
        rd(12'hB02);
        n_cmp++; if (csr_rdata !== 64'd5) begin n_bad++; $display("FAIL minstret_write_wins got %h want 5", csr_rdata); end
        drive(1, 2'b10, 12'hB02, 64'h0, 0, 0, 0, 0, 1);
        tick();
        rd(12'hB02);
        n_cmp++; if (csr_rdata !== 64'd6) begin n_bad++; $display("FAIL minstret_incr got %h want 6", csr_rdata); end
        tick();
    endtask

    task automatic test_priority();
        // mstatus is 0x1888 here: MIE=1, MPIE=1.
        drive(1, 2'b01, 12'h340, 64'h55, 1, 64'h7, 64'h1234_5678, 1, 0);
        n_cmp++; if (redirect_pc !== 64'h8000_0100) begin n_bad++; $display("FAIL prio_redirect got %h want %h", redirect_pc, 64'h8000_0100); end
        tick();
        rd(12'h340);
        n_cmp++; if (csr_rdata !== 64'h0) begin n_bad++; $display("FAIL prio_mscratch got %h want 0", csr_rdata); end
        tick();
        rd(12'h300);
        n_cmp++; if (csr_rdata !== 64'h1880) begin n_bad++; $display("FAIL prio_mstatus got %h want 1880", csr_rdata); end
        tick();
        rd(12'h341);
        n_cmp++; if (csr_rdata !== 64'h1234_5678) begin n_bad++; $display("FAIL prio_mepc got %h want 12345678", csr_rdata); end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [10];
        logic [11:0] a;
        logic [63:0] wd;
        logic [1:0]  op;
        bit          v, tv, mv, rt;
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hF14, 12'h7C0, 12'hC00};
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            a   = addrs[$urandom_range(0, 9)];
            op  = 2'($urandom_range(0, 3));
            v   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       wd = 64'h0;
                1:       wd = 64'($urandom_range(0, 255));
                default: wd = {$urandom, $urandom};
            endcase
            tv = ($urandom_range(0, 9) == 0);
            mv = ($urandom_range(0, 9) == 0);
            rt = $urandom_range(0, 1) == 1;
            drive(v, op, a, wd, tv, {$urandom, $urandom}, {$urandom, $urandom}, mv, rt);
            n_cmp++; if (csr_rdata !== m_read(a)) begin n_bad++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", i, a, csr_rdata, m_read(a)); end
            n_cmp++; if (csr_illegal !== m_illegal(v, op, a, wd)) begin n_bad++; $display("FAIL rnd_illegal[%0d] got %b want %b", i, csr_illegal, m_illegal(v, op, a, wd)); end
            n_cmp++; if (redirect_valid !== (tv | mv) || redirect_pc !== m_redirect()) begin n_bad++; $display("FAIL rnd_redirect[%0d] got %b/%h want %b/%h", i, redirect_valid, redirect_pc, tv | mv, m_redirect()); end
            n_cmp++; if (mie_out !== m_mie) begin n_bad++; $display("FAIL rnd_mie[%0d] got %b want %b", i, mie_out, m_mie); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mtvec();
        test_trap_mret();
        test_illegal();
        test_counters();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
